// File: rtl/trena_multicanal.sv
// Multi-channel HC-SR04 ranging controller: round-robin trigger, echo width
// measured straight into saturating BCD centimetres, one handshaken beat per channel.
module trena_multicanal #(
  parameter int  N_CH           = 2,
  parameter int  TRIG_CYCLES    = 500,
  parameter int  CYCLES_PER_CM  = 2941,
  parameter int  TIMEOUT_CYCLES = 1500000,
  parameter int  GAP_CYCLES     = 3000000,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mensurar,
  input  logic            modo,
  input  logic [N_CH-1:0] echo,
  input  logic            medida_aceita,
  output logic [N_CH-1:0] trigger,
  output logic            medida_valida,
  output logic [CH_W-1:0] canal,
  output logic [3:0]      centena,
  output logic [3:0]      dezena,
  output logic [3:0]      unidade,
  output logic            erro,
  output logic            pronto,
  output logic [3:0]      db_estado
);

  localparam int MAX_A = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int SUB_W = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'd0,
    S_PREPARACAO = 4'd1,
    S_DISPARA    = 4'd2,
    S_ESPERA     = 4'd3,
    S_MEDE       = 4'd4,
    S_ARMAZENA   = 4'd5,
    S_ENVIA      = 4'd6,
    S_INTERVALO  = 4'd7,
    S_FIM        = 4'd8
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SUB_W-1:0] r_sub, w_sub_next;
  logic [11:0]      r_bcd, w_bcd_next;
  logic             r_erro_m;
  logic [CH_W-1:0]  r_ch;
  logic [N_CH-1:0]  r_echo_s1, r_echo_s2;
  logic             r_mens_d;
  logic [CH_W-1:0]  r_o_canal;
  logic [11:0]      r_o_bcd;
  logic             r_o_erro;
  logic             w_echo, w_mens_rise, w_tmo, w_last_ch, w_sub_wrap;

  // Three-digit BCD increment that sticks at 999 instead of rolling over.
  function automatic logic [11:0] bcd_inc_sat(input logic [11:0] d);
    logic [3:0] c, t, u;
    {c, t, u} = d;
    if (d == 12'h999) return d;
    if (u != 4'd9) u = u + 4'd1;
    else begin
      u = 4'd0;
      if (t != 4'd9) t = t + 4'd1;
      else begin
        t = 4'd0;
        c = c + 4'd1;
      end
    end
    return {c, t, u};
  endfunction

  assign w_echo      = r_echo_s2[r_ch];
  assign w_mens_rise = mensurar & ~r_mens_d;
  assign w_tmo       = (r_cnt == TMO_LAST);
  assign w_last_ch   = (r_ch == CH_LAST);
  assign w_sub_wrap  = (r_sub == SUB_LAST);
  assign w_sub_next  = w_sub_wrap ? '0 : r_sub + 1'b1;
  assign w_bcd_next  = w_sub_wrap ? bcd_inc_sat(r_bcd) : r_bcd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_INICIAL;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INICIAL:    if (w_mens_rise || modo) w_next = S_PREPARACAO;
      S_PREPARACAO: w_next = S_DISPARA;
      S_DISPARA:    if (r_cnt == TRIG_LAST) w_next = S_ESPERA;
      S_ESPERA: begin
        if (w_echo)     w_next = S_MEDE;
        else if (w_tmo) w_next = S_ARMAZENA;
      end
      S_MEDE:       if (!w_echo || w_tmo) w_next = S_ARMAZENA;
      S_ARMAZENA:   w_next = S_ENVIA;
      S_ENVIA: begin
        if (medida_aceita) w_next = (w_last_ch && !modo) ? S_FIM : S_INTERVALO;
      end
      S_INTERVALO:  if (r_cnt == GAP_LAST) w_next = S_PREPARACAO;
      S_FIM:        w_next = S_INICIAL;
      default:      w_next = S_INICIAL;
    endcase
  end

  // The first synchronised-high cycle is seen in espera, so counting there too
  // makes the total equal the echo width in clocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_sub     <= '0;
      r_bcd     <= '0;
      r_erro_m  <= 1'b0;
      r_ch      <= '0;
      r_echo_s1 <= '0;
      r_echo_s2 <= '0;
      r_mens_d  <= 1'b0;
      r_o_canal <= '0;
      r_o_bcd   <= '0;
      r_o_erro  <= 1'b0;
    end else begin
      r_mens_d  <= mensurar;
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_cnt     <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_PREPARACAO: begin
          r_sub    <= '0;
          r_bcd    <= '0;
          r_erro_m <= 1'b0;
        end
        S_ESPERA: begin
          if (w_echo) begin
            r_sub <= w_sub_next;
            r_bcd <= w_bcd_next;
          end else if (w_tmo) begin
            r_erro_m <= 1'b1;
          end
        end
        S_MEDE: begin
          if (w_echo) begin
            r_sub <= w_sub_next;
            r_bcd <= w_bcd_next;
            if (w_tmo) r_erro_m <= 1'b1;
          end
        end
        S_ARMAZENA: begin
          r_o_canal <= r_ch;
          r_o_bcd   <= r_erro_m ? 12'h999 : r_bcd;
          r_o_erro  <= r_erro_m;
        end
        S_ENVIA: begin
          if (medida_aceita) r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Trigger is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    trigger = '0;
    if (r_state == S_DISPARA) begin
      for (int i = 0; i < N_CH; i++) trigger[i] = (r_ch == CH_W'(i));
    end
  end

  assign medida_valida = (r_state == S_ENVIA);
  assign pronto        = (r_state == S_FIM);
  assign db_estado     = r_state;
  assign canal         = r_o_canal;
  assign centena       = r_o_bcd[11:8];
  assign dezena        = r_o_bcd[7:4];
  assign unidade       = r_o_bcd[3:0];
  assign erro          = r_o_erro;

endmodule

// File: tb/tb_trena_multicanal.sv
// Bench for trena_multicanal: a sensor model answers each trigger, and every
// accepted beat is compared with floor(width/CYCLES_PER_CM) or the 999 error code.
module tb_trena_multicanal;
  localparam int N_CH = 2;
  localparam int TRIG = 4;
  localparam int CPC  = 10;
  localparam int TMO  = 200;
  localparam int GAP  = 20;

  logic       clock, reset, mensurar, modo, medida_aceita;
  logic [1:0] echo, trigger;
  logic       medida_valida, erro, pronto;
  logic [0:0] canal;
  logic [3:0] centena, dezena, unidade, db_estado;

  trena_multicanal #(
    .N_CH(N_CH), .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC),
    .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .modo(modo),
    .echo(echo), .medida_aceita(medida_aceita), .trigger(trigger),
    .medida_valida(medida_valida), .canal(canal), .centena(centena),
    .dezena(dezena), .unidade(unidade), .erro(erro), .pronto(pronto),
    .db_estado(db_estado)
  );

  typedef struct {bit norise; int delay; int width;} resp_t;
  typedef struct {int canal; logic [11:0] dig; bit erro;} beat_t;

  resp_t plan[$];
  beat_t exp_q[$];
  int    log_canal[$];
  int    log_dig[$];
  int    log_erro[$];
  int    n_pass = 0;
  int    n_total = 0;
  int    pronto_cnt = 0;
  int    acc_mode = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [11:0] model_digits(input int w);
    int d;
    logic [11:0] r;
    d = w / CPC;
    if (d > 999) d = 999;
    r[11:8] = 4'(d / 100);
    r[7:4]  = 4'((d / 10) % 10);
    r[3:0]  = 4'(d % 10);
    return r;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    medida_aceita = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (acc_mode)
        0:       medida_aceita = 1'b1;
        1:       medida_aceita = 1'($urandom_range(0, 1));
        default: medida_aceita = 1'b0;
      endcase
    end
  end

  // Sensor model: answers the end of each trigger pulse with an echo and
  // records what the controller must report for it.
  initial begin
    logic [1:0] prev;
    int    fell;
    resp_t r;
    beat_t e;
    echo = '0;
    prev = '0;
    forever begin
      @(negedge clock);
      fell = -1;
      if (reset) begin
        for (int c = 0; c < N_CH; c++) if (prev[c] && !trigger[c]) fell = c;
      end
      prev = trigger;
      if (fell >= 0) begin
        if (plan.size() > 0) r = plan.pop_front();
        else begin
          r.norise = ($urandom_range(0, 7) == 0);
          r.delay  = int'($urandom_range(1, 30));
          r.width  = int'($urandom_range(1, 150));
        end
        e.canal = fell;
        e.erro  = r.norise || (r.width > TMO);
        e.dig   = e.erro ? 12'h999 : model_digits(r.width);
        exp_q.push_back(e);
        if (!r.norise) begin
          repeat (r.delay) @(posedge clock);
          #1 echo[fell] = 1'b1;
          repeat (r.width) @(posedge clock);
          #1 echo[fell] = 1'b0;
        end
        prev = '0;
      end
    end
  end

  // Cycle-by-cycle compare against the sensor model's expectations.
  initial begin
    int         cyc, trig_run, acc_cyc;
    bit         gap_pending;
    logic       prev_valid, prev_acc, prev_pronto;
    logic [1:0] prev_trig;
    logic [13:0] prev_data;
    beat_t      e;
    cyc = 0; trig_run = 0; acc_cyc = 0; gap_pending = 0;
    prev_valid = 0; prev_acc = 0; prev_pronto = 0; prev_trig = '0; prev_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        trig_run = 0; gap_pending = 0; prev_valid = 0; prev_acc = 0;
        prev_pronto = 0; prev_trig = '0;
      end else begin
        if (trigger != 0) begin
          chk("trig_onehot", $countones(trigger), 1);
          if (prev_trig == 0 && gap_pending) begin
            chk("gap_to_trigger", cyc - acc_cyc, GAP + 2);
            gap_pending = 0;
          end
          trig_run++;
        end else if (trig_run != 0) begin
          chk("trig_width", trig_run, TRIG);
          trig_run = 0;
        end
        if (medida_valida) begin
          chk("trig_low_valid", trigger, 0);
          if (prev_valid && !prev_acc)
            chk("hold_stable", {canal, centena, dezena, unidade, erro}, prev_data);
        end
        if (medida_valida && medida_aceita) begin
          if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_canal", canal, e.canal);
            chk("beat_digits", {centena, dezena, unidade}, e.dig);
            chk("beat_erro", erro, e.erro);
          end
          log_canal.push_back(int'(canal));
          log_dig.push_back(int'({centena, dezena, unidade}));
          log_erro.push_back(int'(erro));
          gap_pending = 1;
          acc_cyc = cyc;
        end
        if (pronto) begin
          chk("pronto_1clk", prev_pronto, 0);
          pronto_cnt++;
          gap_pending = 0;
        end
        prev_valid = medida_valida; prev_acc = medida_aceita; prev_pronto = pronto;
        prev_trig = trigger; prev_data = {canal, centena, dezena, unidade, erro};
      end
    end
  end

  task automatic pulse_mensurar();
    @(posedge clock);
    #1 mensurar = 1'b1;
    repeat (2) @(posedge clock);
    #1 mensurar = 1'b0;
  endtask

  task automatic wait_pronto(input int target, input int budget);
    int k = 0;
    while (pronto_cnt < target && k < budget) begin
      @(negedge clock);
      k++;
    end
    chk("sweep_done", pronto_cnt, target);
  endtask

  task automatic chk_beat(input string nm, input int idx, input int c, input int d, input int e);
    chk({nm, "_present"}, (log_dig.size() > idx) ? 1 : 0, 1);
    if (log_dig.size() > idx) begin
      chk({nm, "_canal"}, log_canal[idx], c);
      chk({nm, "_digits"}, log_dig[idx], d);
      chk({nm, "_erro"}, log_erro[idx], e);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_trigger"}, trigger, 0);
    chk({nm, "_valid"}, medida_valida, 0);
    chk({nm, "_canal"}, canal, 0);
    chk({nm, "_digits"}, {centena, dezena, unidade}, 0);
    chk({nm, "_erro"}, erro, 0);
    chk({nm, "_pronto"}, pronto, 0);
    chk({nm, "_estado"}, db_estado, 0);
  endtask

  initial begin
    int b, p, k, saved;
    reset = 1'b0; mensurar = 1'b0; modo = 1'b0; acc_mode = 0;
    repeat (3) @(negedge clock);
    chk_outputs_zero("rst");
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_after_reset", db_estado, 0);

    // single sweep
    plan.push_back('{0, 3, 123});
    plan.push_back('{0, 5, 57});
    b = log_dig.size(); p = pronto_cnt;
    pulse_mensurar();
    wait_pronto(p + 1, 3000);
    chk_beat("ss0", b, 0, 'h012, 0);
    chk_beat("ss1", b + 1, 1, 'h005, 0);
    chk("ss_beats", log_dig.size() - b, 2);

    // timeouts: no rise, then echo stuck high
    plan.push_back('{0, 4, 40});
    plan.push_back('{1, 0, 0});
    plan.push_back('{0, 2, 25});
    plan.push_back('{0, 3, 300});
    b = log_dig.size(); p = pronto_cnt;
    pulse_mensurar();
    wait_pronto(p + 1, 3000);
    pulse_mensurar();
    wait_pronto(p + 2, 3000);
    repeat (120) @(negedge clock);
    chk_beat("to0", b, 0, 'h004, 0);
    chk_beat("to1", b + 1, 1, 'h999, 1);
    chk_beat("to2", b + 2, 0, 'h002, 0);
    chk_beat("to3", b + 3, 1, 'h999, 1);

    // boundary around one centimetre
    plan.push_back('{0, 2, 9});
    plan.push_back('{0, 2, 10});
    b = log_dig.size(); p = pronto_cnt;
    pulse_mensurar();
    wait_pronto(p + 1, 3000);
    chk_beat("bd9", b, 0, 'h000, 0);
    chk_beat("bd10", b + 1, 1, 'h001, 0);

    // backpressure
    acc_mode = 2;
    plan.push_back('{0, 3, 50});
    plan.push_back('{0, 3, 20});
    b = log_dig.size(); p = pronto_cnt;
    pulse_mensurar();
    k = 0;
    while (!medida_valida && k < 1000) begin
      @(negedge clock);
      k++;
    end
    chk("bp_valid_seen", medida_valida, 1);
    repeat (50) @(negedge clock);
    chk("bp_state", db_estado, 6);
    chk("bp_valid_held", medida_valida, 1);
    chk("bp_trig_low", trigger, 0);
    chk("bp_data", {canal, centena, dezena, unidade}, 'h005);
    acc_mode = 0;
    wait_pronto(p + 1, 3000);
    chk_beat("bp0", b, 0, 'h005, 0);
    chk_beat("bp1", b + 1, 1, 'h002, 0);

    // continuous mode, dropped during a ch0 measurement
    for (int i = 0; i < 12; i++) plan.push_back('{0, 2, 35});
    b = log_dig.size(); p = pronto_cnt;
    @(negedge clock);
    modo = 1'b1;
    k = 0;
    while (log_dig.size() < b + 4 && k < 3000) begin
      @(negedge clock);
      k++;
    end
    k = 0;
    while (trigger[0] !== 1'b1 && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk("cont_trig0_seen", trigger[0], 1);
    modo = 1'b0;
    wait_pronto(p + 1, 3000);
    chk("cont_beats_even", (log_dig.size() - b) % 2, 0);
    chk("cont_min_beats", (log_dig.size() - b >= 6) ? 1 : 0, 1);
    for (int i = b; i < log_dig.size(); i++) begin
      chk("cont_digits", log_dig[i], 'h003);
      chk("cont_canal", log_canal[i], (i - b) % 2);
    end
    saved = log_dig.size();
    repeat (100) @(negedge clock);
    chk("cont_idle_state", db_estado, 0);
    chk("cont_no_more_beats", log_dig.size(), saved);
    plan.delete();

    // randomized sweeps with random accept
    acc_mode = 1;
    for (int s = 0; s < 6; s++) begin
      p = pronto_cnt;
      pulse_mensurar();
      wait_pronto(p + 1, 4000);
    end
    acc_mode = 0;

    // asynchronous reset in the middle of a trigger pulse
    pulse_mensurar();
    k = 0;
    while (trigger == 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("rst2_trig_seen", (trigger != 0) ? 1 : 0, 1);
    #2 reset = 1'b0;
    #1 chk_outputs_zero("rst2");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    saved = log_dig.size();
    repeat (40) @(negedge clock);
    chk("rst2_idle_state", db_estado, 0);
    chk("rst2_idle_trig", trigger, 0);
    chk("rst2_no_beats", log_dig.size(), saved);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
